sme_match_collector: RTL and testbench
======================================

Name: sme_match_collector

Overview:
- Sits directly downstream of the Pigasus SME wrapper in the accelerator slot.
- Consumes the serialized per-packet match stream (rule IDs, then a zero-ID end-of-packet marker) and buffers accepted rule IDs in an ID FIFO for the RISC-V core.
- Pairs each packet's match summary with the 64-bit preamble state the wrapper emits at that packet's tlast.
- Presents one summary record per packet: count, overflow flag, state.

Parameters:
- ID_DEPTH, 32, ID FIFO depth in entries; power of two.
- MATCH_LIMIT, 16, maximum rule IDs stored per packet; must be ≤ ID_DEPTH.
- STATE_DEPTH, 4, preamble-state FIFO depth; power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- match_rule_ID  in  16  rule ID from SME; 0 = end-of-packet marker
- match_valid  in  1  match_rule_ID valid
- match_release  out  1  consume current match word
- state_in  in  64  preamble state for the completed packet
- state_in_valid  in  1  single-cycle pulse; no backpressure
- id_data  out  16  head of ID FIFO
- id_valid  out  1  ID FIFO non-empty
- id_ready  in  1  pop ID FIFO
- done_count  out  8  matches seen in packet, saturating
- done_overflow  out  1  at least one ID dropped for this packet
- done_state  out  64  preamble state paired with packet
- done_valid  out  1  summary valid
- done_ready  in  1  summary accepted
- state_overrun  out  1  sticky: state pulse arrived with state FIFO full

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - match_release=0, done_valid=0, id_valid=0, state_overrun=0.
  - done_count=0, done_overflow=0.
  - Both FIFOs empty; FSM in COLLECT.
- A reset mid-packet discards all buffered IDs, states and partial counts.
- FSM states:
  - COLLECT:
    - match_release=1 (combinational from state).
    - On match_valid with ID≠0 (consumed): increment pkt_count, saturating at 255.
    - Push the ID if stored_this_pkt<MATCH_LIMIT and the ID FIFO is not full (push also valid when id_ready pops the same cycle). Otherwise drop the ID and set pkt_ovf.
    - On match_valid with ID=0 (consumed): go to DONE and latch pkt_count/pkt_ovf into done_count/done_overflow.
  - DONE:
    - match_release=0; SME is back-pressured.
    - done_valid = state FIFO non-empty; done_state = state FIFO head.
    - On done_valid && done_ready: pop the state FIFO, clear pkt_count, stored_this_pkt and pkt_ovf, and return to COLLECT next cycle.
    - match_release re-asserts in the cycle after the handshake.
- The ID FIFO is first-word-fall-through. id_data is valid while id_valid is high. Pop on id_valid && id_ready. Push and pop in the same cycle keep occupancy unchanged.
- The state FIFO is independent of the FSM:
  - A push occurs on every state_in_valid.
  - If the FIFO is full and no pop happens that cycle, the pulse is dropped and state_overrun is set until reset.
  - Simultaneous push and pop on a full FIFO is legal and loses nothing.
- Summaries emerge in packet order. States arrive before or after their marker. A packet with zero matches produces done_count=0.
- Latency:
  - An ID is visible at id_valid 1 cycle after its consume cycle.
  - done_valid rises 1 cycle after marker consumption if a state is already buffered. Otherwise it rises 1 cycle after the state pulse.
- IDs from consecutive packets are not separated in the ID FIFO. The core uses stored count = min(done_count, MATCH_LIMIT) minus drops; because of this, done_overflow means "do not trust the count".

Test Plan:
- IDs 5,9,0x1234 then marker, with a state pulse 0xA5 in the same cycle as the marker → id_data sequence 5,9,0x1234; one summary: count=3, ovf=0, state=0xA5; match_release high throughout except the DONE cycle.
- 20 IDs then marker, MATCH_LIMIT=16, id_ready=1 → 16 IDs popped, count=20, ovf=1.
- Marker only, with the state pulse 10 cycles later → done_valid rises exactly 1 cycle after the pulse; count=0; match_release=0 throughout the wait.
- Five state pulses with no markers, STATE_DEPTH=4 → state_overrun=1. Then four markers → four summaries carrying the first four states in order.
- done_ready held low 50 cycles while match_valid=1 → no IDs consumed, done_valid stable. Release done_ready → COLLECT resumes the next cycle.
- Assert rst while 3 IDs are buffered and in DONE → next cycle id_valid=0, done_valid=0, match_release=0, then 1 the following cycle.

Source files
------------

// File: rtl/sme_match_collector.sv
// Collects the per-packet rule-ID stream from the SME wrapper, buffers IDs for the core
// and pairs each packet's match summary with its preamble state.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   COLLECT | consuming match words; IDs go to the ID FIFO, count/ovf accumulate
//   DONE    | marker seen; SME held off until the summary handshake completes
module sme_match_collector #(
  parameter int ID_DEPTH    = 32,
  parameter int MATCH_LIMIT = 16,
  parameter int STATE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] match_rule_ID,
  input  logic        match_valid,
  output logic        match_release,
  input  logic [63:0] state_in,
  input  logic        state_in_valid,
  output logic [15:0] id_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [7:0]  done_count,
  output logic        done_overflow,
  output logic [63:0] done_state,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        state_overrun
);

  localparam int IAW = $clog2(ID_DEPTH);
  localparam int SAW = $clog2(STATE_DEPTH);
  localparam int SCW = $clog2(MATCH_LIMIT + 1);
  localparam logic [SCW-1:0] LIMIT    = SCW'(MATCH_LIMIT);
  localparam logic [IAW:0]   ID_FULL  = (IAW+1)'(ID_DEPTH);
  localparam logic [SAW:0]   ST_FULL  = (SAW+1)'(STATE_DEPTH);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DONE    = 1'b1;

  logic [0:0]     state_q, state_d;
  logic           run_q;
  logic [7:0]     pkt_count_q, pkt_count_d;
  logic [SCW-1:0] stored_q, stored_d;
  logic           pkt_ovf_q, pkt_ovf_d;
  logic [7:0]     done_count_q, done_count_d;
  logic           done_ovf_q, done_ovf_d;

  logic [15:0]    id_mem [ID_DEPTH];
  logic [IAW-1:0] id_wr_q, id_rd_q;
  logic [IAW:0]   id_cnt_q;
  logic           id_push, id_pop, id_full;

  logic [63:0]    st_mem [STATE_DEPTH];
  logic [SAW-1:0] st_wr_q, st_rd_q;
  logic [SAW:0]   st_cnt_q;
  logic           st_push, st_pop, st_full, st_empty;
  logic           overrun_q;

  logic           consume, is_marker;

  // run_q keeps the SME held off for the first cycle out of reset
  assign match_release = run_q && (state_q == COLLECT);
  assign consume       = match_valid && match_release;
  assign is_marker     = (match_rule_ID == 16'd0);

  assign id_full  = (id_cnt_q == ID_FULL);
  assign id_valid = (id_cnt_q != '0);
  assign id_data  = id_mem[id_rd_q];
  assign id_pop   = id_valid && id_ready;

  assign st_full    = (st_cnt_q == ST_FULL);
  assign st_empty   = (st_cnt_q == '0);
  assign done_valid = (state_q == DONE) && !st_empty;
  assign done_state = st_mem[st_rd_q];
  assign st_pop     = done_valid && done_ready;
  assign st_push    = state_in_valid && (!st_full || st_pop);

  assign done_count    = done_count_q;
  assign done_overflow = done_ovf_q;
  assign state_overrun = overrun_q;

  always_comb begin
    state_d      = state_q;
    pkt_count_d  = pkt_count_q;
    stored_d     = stored_q;
    pkt_ovf_d    = pkt_ovf_q;
    done_count_d = done_count_q;
    done_ovf_d   = done_ovf_q;
    id_push      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (consume && !is_marker) begin
          if (pkt_count_q != 8'hFF) pkt_count_d = pkt_count_q + 8'd1;
          if ((stored_q < LIMIT) && (!id_full || id_pop)) begin
            id_push  = 1'b1;
            stored_d = stored_q + 1'b1;
          end else begin
            pkt_ovf_d = 1'b1;
          end
        end else if (consume) begin
          state_d      = DONE;
          done_count_d = pkt_count_q;
          done_ovf_d   = pkt_ovf_q;
        end
      end
      default: begin
        if (st_pop) begin
          state_d     = COLLECT;
          pkt_count_d = '0;
          stored_d    = '0;
          pkt_ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      run_q        <= 1'b0;
      pkt_count_q  <= '0;
      stored_q     <= '0;
      pkt_ovf_q    <= 1'b0;
      done_count_q <= '0;
      done_ovf_q   <= 1'b0;
      id_wr_q      <= '0;
      id_rd_q      <= '0;
      id_cnt_q     <= '0;
      st_wr_q      <= '0;
      st_rd_q      <= '0;
      st_cnt_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      pkt_count_q  <= pkt_count_d;
      stored_q     <= stored_d;
      pkt_ovf_q    <= pkt_ovf_d;
      done_count_q <= done_count_d;
      done_ovf_q   <= done_ovf_d;

      if (id_push) id_wr_q <= id_wr_q + 1'b1;
      if (id_pop)  id_rd_q <= id_rd_q + 1'b1;
      case ({id_push, id_pop})
        2'b10:   id_cnt_q <= id_cnt_q + 1'b1;
        2'b01:   id_cnt_q <= id_cnt_q - 1'b1;
        default: id_cnt_q <= id_cnt_q;
      endcase

      if (st_push) st_wr_q <= st_wr_q + 1'b1;
      if (st_pop)  st_rd_q <= st_rd_q + 1'b1;
      case ({st_push, st_pop})
        2'b10:   st_cnt_q <= st_cnt_q + 1'b1;
        2'b01:   st_cnt_q <= st_cnt_q - 1'b1;
        default: st_cnt_q <= st_cnt_q;
      endcase

      if (state_in_valid && st_full && !st_pop) overrun_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; occupancy counters define validity.
  always_ff @(posedge clk) begin
    if (id_push) id_mem[id_wr_q] <= match_rule_ID;
    if (st_push) st_mem[st_wr_q] <= state_in;
  end

endmodule

// File: tb/tb_sme_match_collector.sv
// Directed bench for sme_match_collector: inputs driven and outputs sampled on the falling edge.
module tb_sme_match_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] match_rule_ID;
  logic        match_valid;
  logic        match_release;
  logic [63:0] state_in;
  logic        state_in_valid;
  logic [15:0] id_data;
  logic        id_valid;
  logic        id_ready;
  logic [7:0]  done_count;
  logic        done_overflow;
  logic [63:0] done_state;
  logic        done_valid;
  logic        done_ready;
  logic        state_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sme_match_collector #(.ID_DEPTH(32), .MATCH_LIMIT(16), .STATE_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .match_rule_ID  (match_rule_ID),
    .match_valid    (match_valid),
    .match_release  (match_release),
    .state_in       (state_in),
    .state_in_valid (state_in_valid),
    .id_data        (id_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .done_count     (done_count),
    .done_overflow  (done_overflow),
    .done_state     (done_state),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .state_overrun  (state_overrun)
  );

  task automatic test_reset();
    rst = 1'b1; match_valid = 1'b0; match_rule_ID = '0; state_in = '0;
    state_in_valid = 1'b0; id_ready = 1'b0; done_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if (match_release !== 1'b0 || done_valid !== 1'b0 || id_valid !== 1'b0 || state_overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: rel=%b dv=%b iv=%b ovr=%b, required 0 0 0 0",
               match_release, done_valid, id_valid, state_overrun);
    end
    total++;
    if (done_count !== 8'd0 || done_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_summary: count=%0d ovf=%b, required 0 0", done_count, done_overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (match_release !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got %b, required 1", match_release);
    end
  endtask

  task automatic test_basic();
    logic [15:0] ids [3];
    ids[0] = 16'd5; ids[1] = 16'd9; ids[2] = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (match_release !== 1'b1) begin
        bad++; $display("FAIL basic_release[%0d]: got %b, required 1", i, match_release);
      end
      if (i > 0) begin
        total++;
        if (id_valid !== 1'b1) begin
          bad++; $display("FAIL basic_id_latency[%0d]: id_valid=%b, required 1", i, id_valid);
        end
      end
      match_valid = 1'b1; match_rule_ID = ids[i];
      @(negedge clk);
    end
    total++;
    if (match_release !== 1'b1) begin
      bad++; $display("FAIL basic_release_marker: got %b, required 1", match_release);
    end
    match_rule_ID = 16'd0; state_in_valid = 1'b1; state_in = 64'hA5;
    @(negedge clk);
    match_valid = 1'b0; state_in_valid = 1'b0;
    total++;
    if (done_valid !== 1'b1 || done_count !== 8'd3 || done_overflow !== 1'b0 || done_state !== 64'hA5) begin
      bad++;
      $display("FAIL basic_summary: dv=%b count=%0d ovf=%b state=%h, required 1 3 0 a5",
               done_valid, done_count, done_overflow, done_state);
    end
    total++;
    if (match_release !== 1'b0) begin
      bad++; $display("FAIL basic_release_done: got %b, required 0", match_release);
    end
    @(negedge clk);
    total++;
    if (match_release !== 1'b1 || done_valid !== 1'b0) begin
      bad++; $display("FAIL basic_return: rel=%b dv=%b, required 1 0", match_release, done_valid);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (id_valid !== 1'b1 || id_data !== ids[i]) begin
        bad++; $display("FAIL basic_id[%0d]: valid=%b data=%h, required 1 %h", i, id_valid, id_data, ids[i]);
      end
      @(negedge clk);
    end
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL basic_id_empty: id_valid=%b, required 0", id_valid);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int popped = 0;
    id_ready = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      if (id_valid) begin
        total++;
        if (id_data !== 16'(popped + 1)) begin
          bad++; $display("FAIL ovf_id_order: got %0d, required %0d", id_data, popped + 1);
        end
        popped++;
      end
      if (i <= 20) begin
        match_valid = 1'b1; match_rule_ID = 16'(i);
      end else if (i == 21) begin
        match_rule_ID = 16'd0; state_in_valid = 1'b1; state_in = 64'hB6;
      end else begin
        match_valid = 1'b0; state_in_valid = 1'b0;
        total++;
        if (done_valid !== 1'b1 || done_count !== 8'd20 || done_overflow !== 1'b1 || done_state !== 64'hB6) begin
          bad++;
          $display("FAIL ovf_summary: dv=%b count=%0d ovf=%b state=%h, required 1 20 1 b6",
                   done_valid, done_count, done_overflow, done_state);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (id_valid) begin
        total++;
        if (id_data !== 16'(popped + 1)) begin
          bad++; $display("FAIL ovf_id_order: got %0d, required %0d", id_data, popped + 1);
        end
        popped++;
      end
      @(negedge clk);
    end
    total++;
    if (popped != 16) begin
      bad++; $display("FAIL ovf_popped: got %0d IDs, required 16", popped);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_late_state();
    match_valid = 1'b1; match_rule_ID = 16'd0;
    @(negedge clk);
    match_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (done_valid !== 1'b0 || match_release !== 1'b0) begin
        bad++; $display("FAIL late_wait[%0d]: dv=%b rel=%b, required 0 0", i, done_valid, match_release);
      end
      if (i == 9) begin
        state_in_valid = 1'b1; state_in = 64'hC3;
      end
      @(negedge clk);
    end
    state_in_valid = 1'b0;
    total++;
    if (done_valid !== 1'b1 || done_count !== 8'd0 || done_overflow !== 1'b0 || done_state !== 64'hC3) begin
      bad++;
      $display("FAIL late_summary: dv=%b count=%0d ovf=%b state=%h, required 1 0 0 c3",
               done_valid, done_count, done_overflow, done_state);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      state_in_valid = 1'b1; state_in = 64'(i * 17);
      @(negedge clk);
    end
    state_in_valid = 1'b0;
    total++;
    if (state_overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_flag: got %b, required 1", state_overrun);
    end
    for (int i = 1; i <= 4; i++) begin
      match_valid = 1'b1; match_rule_ID = 16'd0;
      @(negedge clk);
      match_valid = 1'b0;
      total++;
      if (done_valid !== 1'b1 || done_count !== 8'd0 || done_state !== 64'(i * 17)) begin
        bad++;
        $display("FAIL overrun_summary[%0d]: dv=%b count=%0d state=%h, required 1 0 %h",
                 i, done_valid, done_count, done_state, 64'(i * 17));
      end
      @(negedge clk);
    end
    total++;
    if (state_overrun !== 1'b1 || done_valid !== 1'b0) begin
      bad++; $display("FAIL overrun_after: ovr=%b dv=%b, required 1 0", state_overrun, done_valid);
    end
  endtask

  task automatic test_stall();
    done_ready = 1'b0;
    match_valid = 1'b1; match_rule_ID = 16'd0; state_in_valid = 1'b1; state_in = 64'h77;
    @(negedge clk);
    state_in_valid = 1'b0; match_rule_ID = 16'h42;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (match_release !== 1'b0 || done_valid !== 1'b1 || id_valid !== 1'b0 || done_state !== 64'h77) begin
        bad++;
        $display("FAIL stall[%0d]: rel=%b dv=%b iv=%b state=%h, required 0 1 0 77",
                 i, match_release, done_valid, id_valid, done_state);
      end
      @(negedge clk);
    end
    done_ready = 1'b1;
    @(negedge clk);
    total++;
    if (match_release !== 1'b1 || done_valid !== 1'b0) begin
      bad++; $display("FAIL stall_resume: rel=%b dv=%b, required 1 0", match_release, done_valid);
    end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b1 || id_data !== 16'h42) begin
      bad++; $display("FAIL stall_id: valid=%b data=%h, required 1 0042", id_valid, id_data);
    end
    match_rule_ID = 16'd0; state_in_valid = 1'b1; state_in = 64'h88;
    @(negedge clk);
    match_valid = 1'b0; state_in_valid = 1'b0;
    total++;
    if (done_valid !== 1'b1 || done_count !== 8'd1 || done_state !== 64'h88) begin
      bad++; $display("FAIL stall_summary: dv=%b count=%0d state=%h, required 1 1 88", done_valid, done_count, done_state);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    done_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      match_valid = 1'b1; match_rule_ID = 16'(i + 100);
      @(negedge clk);
    end
    match_rule_ID = 16'd0; state_in_valid = 1'b1; state_in = 64'h99;
    @(negedge clk);
    match_valid = 1'b0; state_in_valid = 1'b0;
    total++;
    if (id_valid !== 1'b1 || done_valid !== 1'b1 || match_release !== 1'b0) begin
      bad++; $display("FAIL midrst_pre: iv=%b dv=%b rel=%b, required 1 1 0", id_valid, done_valid, match_release);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (id_valid !== 1'b0 || done_valid !== 1'b0 || match_release !== 1'b0 || done_count !== 8'd0) begin
      bad++;
      $display("FAIL midrst_clear: iv=%b dv=%b rel=%b count=%0d, required 0 0 0 0",
               id_valid, done_valid, match_release, done_count);
    end
    @(negedge clk);
    total++;
    if (match_release !== 1'b1 || id_valid !== 1'b0 || done_valid !== 1'b0 || state_overrun !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after: rel=%b iv=%b dv=%b ovr=%b, required 1 0 0 0",
               match_release, id_valid, done_valid, state_overrun);
    end
    done_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_late_state();
    test_overrun();
    test_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
